mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage consumer of the decoder's MemRead/MemWrite codes: turns them into word-wide bus transactions.
// - Handles byte/half/word lanes, sign-extends loads and stalls the pipeline until the bus acknowledges.
// - Sits between the EX/MEM pipeline register and the external data memory.
// - Codes: 00 none, 01 word (lw/sw), 10 byte (lb/sb), 11 half (lh/sh).
// PARAMETERS
// - TIMEOUT   default 255   max ACCESS cycles waiting for mem_ack before bus_err (1..255)
// PORTS
// - clk        in   1   system clock, rising edge
// - reset      in   1   asynchronous, active-high reset
// - mem_read   in   2   load size code from pipeline
// - mem_write  in   2   store size code from pipeline
// - addr       in   32  byte address (ALU result)
// - wdata      in   32  store data (rt value); low byte/half used for sb/sh
// - mem_ack    in   1   bus acknowledge, 1-cycle pulse, valid in ACCESS only
// - mem_rdata  in   32  bus read word, valid with mem_ack
// - mem_req    out  1   bus request, held high until mem_ack or timeout
// - mem_we     out  1   1 = write transaction
// - mem_be     out  4   byte enables, bit n = byte lane n (bits 8n+7:8n)
// - mem_addr   out  32  word address, {addr[31:2],2'b00}
// - mem_wdata  out  32  store data replicated to all lanes (byte x4, half x2)
// - load_data  out  32  sign-extended load result, valid while done=1
// - done       out  1   1-cycle pulse: transaction finished
// - stall      out  1   combinational; freezes PC, IF/ID, ID/EX, EX/MEM
// - align_err  out  1   1-cycle pulse: misaligned or illegal access
// - bus_err    out  1   1-cycle pulse, with done: timeout
// BEHAVIOUR
// - Little-endian lanes: addr[1:0]=0 -> mem_be 0001 for byte, addr[1]=0 -> 0011 for half, word -> 1111.
// - Reset (async): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, done, align_err, bus_err, timer all 0.
// - Reset mid-transaction: mem_req drops immediately; the transaction is abandoned, no done.
// - FSM IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE, no op: stall=0.
// - IDLE, op valid and aligned: stall=1; register mem_addr/mem_we/mem_be/mem_wdata; mem_req=1; -> ACCESS.
// - IDLE, illegal op (lw/sw addr[1:0]!=0; lh/sh addr[0]=1; or both codes nonzero): align_err=1, stall=0, no bus cycle, stay IDLE.
// - ACCESS: stall=1; timer increments each cycle.
//   - mem_ack=1: drop mem_req; capture mem_rdata lane-extracted and sign-extended into load_data (stores: load_data 0); -> DONE.
//   - timer reaches TIMEOUT without ack: drop mem_req; load_data=0; bus_err=1 registered for the DONE cycle; -> DONE.
//   - mem_ack and timeout in the same cycle: ack wins, no bus_err.
// - DONE: done=1, stall=0; the pipeline advances at this edge; -> IDLE and clear timer. Inputs are not sampled in DONE.
// - Minimum latency with ack in the first ACCESS cycle: issue at cycle 0, ack at cycle 1, done at cycle 2 (stall high for cycles 0-1).
// - mem_ack outside ACCESS is ignored.
// - Sign extension: byte -> {24{b[7]},b}; half -> {16{h[15]},h}; word unchanged.
// TESTING
// - lb addr=0x103, mem_rdata=0x80_11_22_33, ack after 2 cycles -> mem_be=1000, mem_addr=0x100, load_data=0xFFFFFF80, stall for 3 cycles then done pulse.
// - sh addr=0x202, wdata=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
// - lw addr=0x006 -> align_err pulse, mem_req stays 0, stall=0 the same cycle.
// - lw with no ack and TIMEOUT=4 -> mem_req high for 4 cycles, then done+bus_err together, load_data=0.
// - reset asserted on cycle 1 of ACCESS -> mem_req=0 asynchronously, no done; the next lw addr=0x10 with ack completes normally.
// - lh addr=0x2, mem_rdata=0x7FFF0000 -> load_data=0x00007FFF; same cycle as the ack, a stray ack in IDLE is ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus between the MEM-stage access unit and the
// external data memory. The unit is the master; the memory answers with a
// one-cycle acknowledge that carries the read word.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: converts MemRead/MemWrite size codes into a single
// word-wide bus transaction with byte enables, lane-replicated store data and
// sign-extended load data. The pipeline is stalled from issue until the cycle
// before done; a missing acknowledge ends the access with bus_err.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  mem_access_unit_if.master bus,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_HALF = 2'b11;
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  timer;
  logic [1:0]  op_size;     // size code of the transaction in flight
  logic [1:0]  op_off;      // addr[1:0] of the transaction in flight

  // Request decode (only meaningful in IDLE)
  logic        is_store;
  logic        any_op;
  logic        illegal;
  logic        issue;
  logic [1:0]  req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rd_ext;
  logic        timer_last;

  // Classify the incoming pipeline request and build lane enables / store data.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    is_store  = (mem_write != SZ_NONE);
    any_op    = (mem_read != SZ_NONE) || is_store;
    req_size  = is_store ? mem_write : mem_read;
    illegal   = 1'b0;
    req_be    = 4'b0000;
    req_wdata = wdata;
    if ((mem_read != SZ_NONE) && is_store) begin
      illegal = 1'b1;
    end
    case (req_size)
      SZ_WORD: begin
        req_be = 4'b1111;
        if (addr[1:0] != 2'b00) illegal = 1'b1;
      end
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
        if (addr[0]) illegal = 1'b1;
      end
      default: req_be = 4'b0000;
    endcase
    issue = any_op && !illegal;
  end

  // Pick the addressed lane out of the read word and sign-extend it.
  always_comb begin
    rd_ext = bus.mem_rdata;
    case (op_size)
      SZ_BYTE: begin
        case (op_off)
          2'd0:    rd_ext = {{24{bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
          2'd1:    rd_ext = {{24{bus.mem_rdata[15]}}, bus.mem_rdata[15:8]};
          2'd2:    rd_ext = {{24{bus.mem_rdata[23]}}, bus.mem_rdata[23:16]};
          default: rd_ext = {{24{bus.mem_rdata[31]}}, bus.mem_rdata[31:24]};
        endcase
      end
      SZ_HALF: begin
        if (op_off[1]) rd_ext = {{16{bus.mem_rdata[31]}}, bus.mem_rdata[31:16]};
        else           rd_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      end
      default: rd_ext = bus.mem_rdata;
    endcase
  end

  // Last permitted ACCESS cycle: the timer would reach TIMEOUT on this edge.
  assign timer_last = ((timer + 8'd1) == TIMEOUT_CNT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and stall; stall is combinational so the issuing cycle freezes too.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          stall      = 1'b1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (bus.mem_ack || timer_last) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus registers, load capture, timer and the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      load_data     <= 32'd0;
      done          <= 1'b0;
      align_err     <= 1'b0;
      bus_err       <= 1'b0;
      timer         <= 8'd0;
      op_size       <= SZ_NONE;
      op_off        <= 2'b00;
    end else begin
      done      <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_store;
            bus.mem_be    <= req_be;
            bus.mem_addr  <= {addr[31:2], 2'b00};
            bus.mem_wdata <= req_wdata;
            op_size       <= req_size;
            op_off        <= addr[1:0];
            timer         <= 8'd0;
          end else if (illegal) begin
            align_err <= 1'b1;
          end
        end
        S_ACCESS: begin
          timer <= timer + 8'd1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            load_data   <= bus.mem_we ? 32'd0 : rd_ext;
            done        <= 1'b1;
          end else if (timer_last) begin
            bus.mem_req <= 1'b0;
            load_data   <= 32'd0;
            bus_err     <= 1'b1;
            done        <= 1'b1;
          end
        end
        S_DONE:  timer <= 8'd0;
        default: timer <= 8'd0;
      endcase
    end
  end

endmodule
